// File: rtl/rr_priority_arbiter.sv
// Round-robin / fixed-priority arbiter with registered grants.
// A grant is held until its requester drops req; after each release
// the arbiter can be forced idle for IDLE_GAP extra cycles.
module rr_priority_arbiter #(
   parameter  int N        = 4,
   parameter  int RR_MODE  = 1,
   parameter  int IDLE_GAP = 0,
   localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt_oh,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_vld
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t        state_reg,   state_next;
   logic [IW-1:0] ptr_reg,     ptr_next;
   logic [3:0]    gap_cnt_reg, gap_cnt_next;
   logic [N-1:0]  gnt_oh_reg,  gnt_oh_next;
   logic [IW-1:0] gnt_idx_reg, gnt_idx_next;
   logic          gnt_vld_reg, gnt_vld_next;

   logic          win_found;
   logic [IW-1:0] win_idx;
   logic [N-1:0]  win_oh;
   int            cand;

   // Winner search: first set request at or above ptr, wrapping at N-1.
   // Scanning from the far end down lets the nearest candidate win last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = (int'(ptr_reg) + k) % N;
         if (req[cand]) begin
            win_found = 1'b1;
            win_idx   = IW'(cand);
         end
      end
   end

   // One-hot form of the winning index.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_win_oh
         assign win_oh[gi] = win_found && (win_idx == IW'(gi));
      end
   endgenerate

   // Next-state and next-output logic; everything holds unless changed.
   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      gap_cnt_next = gap_cnt_reg;
      gnt_oh_next  = gnt_oh_reg;
      gnt_idx_next = gnt_idx_reg;
      gnt_vld_next = gnt_vld_reg;
      case (state_reg)
         ST_IDLE: begin
            if (win_found) begin
               gnt_oh_next  = win_oh;
               gnt_idx_next = win_idx;
               gnt_vld_next = 1'b1;
               state_next   = ST_GRANT;
               // Fixed priority keeps the search anchored at channel 0.
               if (RR_MODE != 0 && int'(win_idx) != N - 1) begin
                  ptr_next = win_idx + IW'(1);
               end else begin
                  ptr_next = '0;
               end
            end
         end
         ST_GRANT: begin
            // Other requesters are ignored; only the owner's release matters.
            if (!req[gnt_idx_reg]) begin
               gnt_oh_next  = '0;
               gnt_idx_next = '0;
               gnt_vld_next = 1'b0;
               gap_cnt_next = '0;
               state_next   = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt_reg == 4'(IDLE_GAP - 1)) begin
               gap_cnt_next = '0;
               state_next   = ST_IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg + 4'd1;
            end
         end
         default: begin
            state_next   = ST_IDLE;
            gnt_oh_next  = '0;
            gnt_idx_next = '0;
            gnt_vld_next = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         ptr_reg     <= '0;
         gap_cnt_reg <= '0;
         gnt_oh_reg  <= '0;
         gnt_idx_reg <= '0;
         gnt_vld_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         gap_cnt_reg <= gap_cnt_next;
         gnt_oh_reg  <= gnt_oh_next;
         gnt_idx_reg <= gnt_idx_next;
         gnt_vld_reg <= gnt_vld_next;
      end
   end

   assign gnt_oh  = gnt_oh_reg;
   assign gnt_idx = gnt_idx_reg;
   assign gnt_vld = gnt_vld_reg;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: four instances (round-robin, fixed
// priority, round-robin with gap 2, single channel with gap 1) share one
// stimulus and are compared every cycle against an ownership model.
module tb_rr_priority_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;

   logic [3:0] oh_rr, oh_fp, oh_gap;
   logic [1:0] idx_rr, idx_fp, idx_gap;
   logic       vld_rr, vld_fp, vld_gap;
   logic [0:0] oh_n1;
   logic [0:0] idx_n1;
   logic       vld_n1;

   logic [3:0] o_oh[4];
   logic [1:0] o_idx[4];
   logic       o_vld[4];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: who owns the grant, how many forced-idle cycles are
   // left, and where the next search starts.
   int m_n[4]     = '{4, 4, 4, 1};
   int m_mode[4]  = '{1, 0, 1, 1};
   int m_gap[4]   = '{0, 0, 2, 1};
   int m_owner[4] = '{-1, -1, -1, -1};
   int m_cool[4]  = '{0, 0, 0, 0};
   int m_start[4] = '{0, 0, 0, 0};

   int   order_q[$];
   logic last_vld0 = 1'b0;

   always #5 clk = ~clk;

   rr_priority_arbiter #(.N(4), .RR_MODE(1), .IDLE_GAP(0)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt_oh(oh_rr), .gnt_idx(idx_rr), .gnt_vld(vld_rr));

   rr_priority_arbiter #(.N(4), .RR_MODE(0), .IDLE_GAP(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt_oh(oh_fp), .gnt_idx(idx_fp), .gnt_vld(vld_fp));

   rr_priority_arbiter #(.N(4), .RR_MODE(1), .IDLE_GAP(2)) dut_gap (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt_oh(oh_gap), .gnt_idx(idx_gap), .gnt_vld(vld_gap));

   rr_priority_arbiter #(.N(1), .RR_MODE(1), .IDLE_GAP(1)) dut_n1 (
      .clk(clk), .rst_n(rst_n), .req(req[0:0]),
      .gnt_oh(oh_n1), .gnt_idx(idx_n1), .gnt_vld(vld_n1));

   assign o_oh[0]  = oh_rr;
   assign o_oh[1]  = oh_fp;
   assign o_oh[2]  = oh_gap;
   assign o_oh[3]  = {3'b000, oh_n1};
   assign o_idx[0] = idx_rr;
   assign o_idx[1] = idx_fp;
   assign o_idx[2] = idx_gap;
   assign o_idx[3] = {1'b0, idx_n1};
   assign o_vld[0] = vld_rr;
   assign o_vld[1] = vld_fp;
   assign o_vld[2] = vld_gap;
   assign o_vld[3] = vld_n1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic model_step(input logic [3:0] r, input logic rn);
      int c;
      for (int i = 0; i < 4; i++) begin
         if (!rn) begin
            m_owner[i] = -1;
            m_cool[i]  = 0;
            m_start[i] = 0;
         end else if (m_owner[i] >= 0) begin
            if (!r[m_owner[i]]) begin
               m_owner[i] = -1;
               m_cool[i]  = m_gap[i];
            end
         end else if (m_cool[i] > 0) begin
            m_cool[i]--;
         end else begin
            for (int k = 0; k < m_n[i]; k++) begin
               c = (m_start[i] + k) % m_n[i];
               if (m_owner[i] < 0 && r[c]) m_owner[i] = c;
            end
            if (m_owner[i] >= 0)
               m_start[i] = (m_mode[i] != 0) ? (m_owner[i] + 1) % m_n[i] : 0;
         end
      end
   endtask

   task automatic compare_all;
      logic       e_vld;
      logic [1:0] e_idx;
      logic [3:0] e_oh;
      for (int i = 0; i < 4; i++) begin
         e_vld = (m_owner[i] >= 0);
         e_idx = e_vld ? 2'(m_owner[i]) : 2'd0;
         e_oh  = e_vld ? (4'b0001 << m_owner[i]) : 4'b0000;
         check($sformatf("c%0d d%0d vld", cyc, i), 32'(o_vld[i]), 32'(e_vld));
         check($sformatf("c%0d d%0d idx", cyc, i), 32'(o_idx[i]), 32'(e_idx));
         check($sformatf("c%0d d%0d oh",  cyc, i), 32'(o_oh[i]),  32'(e_oh));
      end
      if (o_vld[0] && !last_vld0) begin
         $display("cycle %0d: dut_rr grants ch%0d (req=%b)", cyc, o_idx[0], req);
         order_q.push_back(int'(o_idx[0]));
      end
      last_vld0 = o_vld[0];
   endtask

   // One clock: drive away from the edge, advance the model at the edge,
   // then compare shortly after.
   task automatic step(input logic [3:0] r, input logic rn);
      @(negedge clk);
      req   = r;
      rst_n = rn;
      @(posedge clk);
      model_step(r, rn);
      #1;
      cyc++;
      compare_all();
   endtask

   initial begin
      logic [3:0] r;
      logic       rn;
      int         age;
      int         exp_order[5] = '{0, 1, 2, 3, 0};

      req   = 4'b0000;
      rst_n = 1'b0;

      // Reset holds everything low even with all requests up.
      repeat (3) begin
         step(4'b1111, 1'b0);
         check("rst_vld", 32'(vld_rr), 32'd0);
         check("rst_oh",  32'(oh_rr),  32'd0);
      end
      step(4'b1111, 1'b1);
      check("rst_first_oh",  32'(oh_rr),  32'b0001);
      check("rst_first_idx", 32'(idx_rr), 32'd0);

      // Fairness: each owner drops its request in its second grant cycle.
      step(4'b0000, 1'b0);
      order_q.delete();
      age = 0;
      for (int t = 0; t < 24; t++) begin
         r = 4'b1111;
         if (m_owner[0] >= 0 && age == 2) r[m_owner[0]] = 1'b0;
         step(r, 1'b1);
         if (m_owner[0] >= 0) age++;
         else age = 0;
      end
      check("rr_order_len", 32'(order_q.size() >= 5), 32'd1);
      for (int k = 0; k < 5; k++) begin
         if (k < order_q.size())
            check($sformatf("rr_order%0d", k), 32'(order_q[k]), 32'(exp_order[k]));
      end

      // Wrap: last grant ch2 leaves ptr at 3, so ch0 wins next, then ch2.
      step(4'b0000, 1'b0);
      step(4'b0100, 1'b1);
      check("wrap_first", 32'(idx_rr), 32'd2);
      step(4'b0100, 1'b1);
      step(4'b0000, 1'b1);
      step(4'b0101, 1'b1);
      check("wrap_ch0", 32'(idx_rr), 32'd0);
      step(4'b0101, 1'b1);
      step(4'b0100, 1'b1);
      step(4'b0100, 1'b1);
      check("wrap_ch2", 32'(idx_rr), 32'd2);
      check("wrap_vld", 32'(vld_rr), 32'd1);

      // Gap and hold: ch3 does not preempt ch1; three low cycles follow.
      step(4'b0000, 1'b0);
      step(4'b0010, 1'b1);
      step(4'b1010, 1'b1);
      step(4'b1010, 1'b1);
      check("gap_hold_idx", 32'(idx_gap), 32'd1);
      step(4'b1000, 1'b1);
      check("gap_low1", 32'(vld_gap), 32'd0);
      step(4'b1000, 1'b1);
      check("gap_low2", 32'(vld_gap), 32'd0);
      step(4'b1000, 1'b1);
      check("gap_low3", 32'(vld_gap), 32'd0);
      step(4'b1000, 1'b1);
      check("gap_next_idx", 32'(idx_gap), 32'd3);
      check("gap_next_vld", 32'(vld_gap), 32'd1);

      // Reset mid-grant: pointer returns to 0, so ch2 wins again over ch3.
      step(4'b0000, 1'b0);
      step(4'b0100, 1'b1);
      step(4'b1100, 1'b0);
      check("midrst_vld", 32'(vld_rr), 32'd0);
      check("midrst_oh",  32'(oh_rr),  32'd0);
      step(4'b1100, 1'b1);
      check("midrst_idx", 32'(idx_rr), 32'd2);

      // Random traffic: owners release at random, other bits wander.
      r = 4'b0000;
      for (int t = 0; t < 600; t++) begin
         for (int b = 0; b < 4; b++) begin
            if (m_owner[0] == b) begin
               if ($urandom_range(3) == 0) r[b] = 1'b0;
            end else if ($urandom_range(4) == 0) begin
               r[b] = ~r[b];
            end
         end
         rn = ($urandom_range(59) != 0);
         step(r, rn);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_priority_arbiter.md
RR_PRIORITY_ARBITER -- requirements
Module: rr_priority_arbiter

Interface
REQ-001 SHALL provide parameter N, default 4, number of requesters, legal range 1..16.
REQ-002 SHALL provide parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-003 SHALL provide parameter IDLE_GAP, default 0, forced idle cycles after each release, legal range 0..15.
REQ-004 SHALL define IW = max(1, clog2(N)).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port req, input, N bits: request per channel, level, held high for the whole transfer.
REQ-008 SHALL have port gnt_oh, output, N bits: registered one-hot grant.
REQ-009 SHALL have port gnt_idx, output, IW bits: binary index of the granted channel.
REQ-010 SHALL have port gnt_vld, output, 1 bit: high while any grant is active.

Function
REQ-011 SHALL implement states IDLE, GRANT and GAP.
REQ-012 IDLE: if req != 0, SHALL load the winner into gnt_oh/gnt_idx, set gnt_vld and enter GRANT at the next edge (1-cycle req-to-grant latency); otherwise SHALL stay in IDLE.
REQ-013 Round-robin winner SHALL be the first set req bit searched upward from pointer ptr, wrapping N-1 -> 0.
REQ-014 ptr SHALL become (granted index + 1) mod N when a grant is issued.
REQ-015 Fixed-priority winner SHALL be the lowest-index set req bit; ptr SHALL be held at 0.
REQ-016 GRANT: grant SHALL hold while req[gnt_idx]=1; changes on other req bits SHALL be ignored.
REQ-017 GRANT: when req[gnt_idx]=0 is sampled, SHALL clear gnt_oh, gnt_idx and gnt_vld at that edge, then enter IDLE if IDLE_GAP=0, else GAP.
REQ-018 GAP: SHALL count IDLE_GAP cycles with outputs cleared, then enter IDLE; req SHALL be ignored during GAP.
REQ-019 Minimum gnt_vld low time between grants SHALL be 1+IDLE_GAP cycles.
REQ-020 gnt_oh SHALL always be one-hot or zero; gnt_oh[gnt_idx] SHALL equal gnt_vld.
REQ-021 N=1: gnt_idx SHALL be constant 0; the channel is granted whenever req[0]=1, subject to gap rules.
REQ-022 Grant decision SHALL be purely registered; no combinational path from req to any output.

Reset
REQ-023 When rst_n=0 at an edge: state SHALL go to IDLE, ptr=0, gap counter=0, gnt_oh=0, gnt_idx=0, gnt_vld=0, regardless of req.
REQ-024 Reset asserted mid-GRANT or mid-GAP SHALL abort at that edge; the first arbitration after release of reset SHALL use ptr=0.

Verification (N=4 unless stated)
REQ-025 Reset: rst_n=0 with req=4'b1111 for 3 cycles -> gnt_vld=0, gnt_oh=0; after rst_n=1 -> gnt_oh=4'b0001, gnt_idx=0 one cycle later.
REQ-026 Round-robin fairness: RR_MODE=1, req=4'b1111; each channel drops req for 1 cycle 2 cycles after its grant -> grant order 0,1,2,3,0; gnt_vld low exactly 1 cycle between grants.
REQ-027 Fixed priority: RR_MODE=0, same stimulus as REQ-026 -> ch0 wins every arbitration while req[0]=1; ch1 wins only when req[0]=0 at the IDLE sample.
REQ-028 Wrap: RR_MODE=1, last grant ch2 (ptr=3), req=4'b0101 -> grant ch0 next, then ch2 after ch0 releases.
REQ-029 Gap plus hold: IDLE_GAP=2, ch1 granted, req[3] rises mid-grant, req[1] drops -> gnt_vld low 3 cycles, then gnt_idx=3; req[3] does not preempt ch1.
REQ-030 Reset mid-grant: ch2 granted, rst_n=0 for 1 cycle with req=4'b1100 -> outputs 0 at that edge; next grant to ch2 (ptr=0 search).
